wb_cmd_master: RTL and testbench
================================

WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: bus cycles allowed for wbm_ack_i before abort; legal range 1..65535.
REQ-002 SHALL have port wb_clk_i, input, 1: sole clock; all logic rising-edge.
REQ-003 SHALL have port wb_rst_i, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port cmd_valid_i, input, 1: command request.
REQ-005 SHALL have port cmd_ready_o, output, 1: command accepted when high with cmd_valid_i.
REQ-006 SHALL have port cmd_we_i, input, 1: 1 = write, 0 = read.
REQ-007 SHALL have port cmd_adr_i, input, 32: byte address.
REQ-008 SHALL have port cmd_dat_i, input, 32: write data.
REQ-009 SHALL have port cmd_sel_i, input, 4: byte lane select.
REQ-010 SHALL have port rsp_valid_o, output, 1: response available.
REQ-011 SHALL have port rsp_ready_i, input, 1: response consumed when high with rsp_valid_o.
REQ-012 SHALL have port rsp_dat_o, output, 32: read data (0 for writes and errors).
REQ-013 SHALL have port rsp_err_o, output, 1: transfer aborted by timeout.
REQ-014 SHALL have ports wbm_cyc_o, wbm_stb_o, wbm_we_o (output, 1 each), wbm_sel_o (output, 4), wbm_adr_o, wbm_dat_o (output, 32): Wishbone classic initiator outputs.
REQ-015 SHALL have ports wbm_dat_i (input, 32), wbm_ack_i (input, 1): Wishbone responder returns.

Function
REQ-016 SHALL implement FSM states IDLE, BUS, RESP; one transfer outstanding at a time.
REQ-017 IDLE: cmd_ready_o = 1; on cmd_valid_i capture we/adr/dat/sel and enter BUS next edge.
REQ-018 BUS: wbm_cyc_o = wbm_stb_o = 1, all wbm outputs registered and stable; cmd_ready_o = 0.
REQ-019 Latency: command accepted at edge N -> wbm_stb_o high from cycle N+1.
REQ-020 BUS: wbm_ack_i sampled high -> capture wbm_dat_i (reads only), drop cyc/stb at that edge, enter RESP; rsp_valid_o high next cycle.
REQ-021 RESP: rsp_valid_o, rsp_dat_o, rsp_err_o held stable until rsp_ready_i sampled high, then IDLE; no new command accepted in that same cycle.
REQ-022 wbm_ack_i outside BUS SHALL be ignored; wbm_dat_o/wbm_adr_o SHALL hold last value when idle.
REQ-023 Writes: rsp_dat_o = 0, rsp_err_o = 0 on acked completion.

Reset
REQ-024 wb_rst_i high SHALL immediately force IDLE, cyc/stb/we/rsp_valid_o/rsp_err_o = 0, sel/adr/dat/rsp_dat_o = 0, cmd_ready_o = 0 while reset asserted, 1 after release.
REQ-025 Reset mid-BUS or mid-RESP SHALL drop the transfer with no response generated.

Configuration
REQ-026 Macro WB_CMD_MASTER_TIMEOUT_EN defined: 16-bit counter cleared on BUS entry, incremented each BUS cycle; ack not seen by TIMEOUT_CYCLES-th BUS cycle -> drop cyc/stb, enter RESP with rsp_err_o = 1, rsp_dat_o = 0; ack on that same cycle wins (normal completion).
REQ-027 Macro undefined: no counter, BUS waits indefinitely, rsp_err_o tied 0.

Verification
REQ-028 Read: cmd adr=0x3000_0004 we=0, responder acks after 2 cycles with 0xDEAD_BEEF -> stb high 3 cycles, rsp_dat_o=0xDEAD_BEEF, rsp_err_o=0.
REQ-029 Write: adr=0x3000_0000 dat=0x0000_00A5 sel=0xF, ack same cycle as first stb -> wbm_we_o=1, wbm_dat_o=0xA5 during stb, rsp_dat_o=0.
REQ-030 Backpressure: rsp_ready_i low 5 cycles -> rsp_valid_o and data held, cmd_ready_o=0 throughout, second command accepted only after response consumed.
REQ-031 Timeout (macro on, TIMEOUT_CYCLES=4): no ack -> stb high exactly 4 cycles, rsp_err_o=1, rsp_dat_o=0; ack on 4th cycle -> rsp_err_o=0.
REQ-032 Reset asserted asynchronously mid-BUS -> cyc/stb low before next edge, no rsp_valid_o after release, next command completes normally.

Source files
------------

// File: rtl/wb_cmd_master_if.sv
// Command/response handshake plus Wishbone classic initiator signals for wb_cmd_master.
// Signal suffixes give the direction as seen from the master (DUT) side.
interface wb_cmd_master_if;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_we_i;
    logic [31:0] cmd_adr_i;
    logic [31:0] cmd_dat_i;
    logic [3:0]  cmd_sel_i;

    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;

    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_dat_o, rsp_err_o,
        input  rsp_ready_i,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_dat_o, rsp_err_o,
        output rsp_ready_i,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i
    );
endinterface

// File: rtl/wb_cmd_master.sv
// Single-outstanding command-to-Wishbone-classic bridge with a held response slot.
// Define WB_CMD_MASTER_TIMEOUT_EN to abort transfers not acked within TIMEOUT_CYCLES bus cycles.
module wb_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    wb_cmd_master_if.master bus_io
);

    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range
        $error("wb_cmd_master: TIMEOUT_CYCLES must be within 1..65535");
    end

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBus  = 2'b01,
        StResp = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q, cnt_d;
    logic        rsp_err_q, rsp_err_d;
    logic        timeout;

    // cnt_q counts completed BUS cycles, so it equals TimeoutLast in the final allowed cycle.
    assign timeout = (cnt_q == TimeoutLast);
`endif

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        we_d      = we_q;
        sel_d     = sel_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        rsp_dat_d = rsp_dat_q;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        cnt_d     = cnt_q;
        rsp_err_d = rsp_err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus_io.cmd_valid_i) begin
                    state_d = StBus;
                    cyc_d   = 1'b1;
                    we_d    = bus_io.cmd_we_i;
                    sel_d   = bus_io.cmd_sel_i;
                    adr_d   = bus_io.cmd_adr_i;
                    dat_d   = bus_io.cmd_dat_i;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            StBus: begin
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                cnt_d = cnt_q + 16'd1;
`endif
                // An ack in the last allowed cycle takes priority over the timeout.
                if (bus_io.wbm_ack_i) begin
                    state_d   = StResp;
                    cyc_d     = 1'b0;
                    rsp_dat_d = we_q ? 32'h0 : bus_io.wbm_dat_i;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
                    rsp_err_d = 1'b0;
                end else if (timeout) begin
                    state_d   = StResp;
                    cyc_d     = 1'b0;
                    rsp_dat_d = 32'h0;
                    rsp_err_d = 1'b1;
`endif
                end
            end
            StResp: begin
                if (bus_io.rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= StIdle;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            rsp_dat_q <= '0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            rsp_dat_q <= rsp_dat_d;
        end
    end

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt_q     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign bus_io.rsp_err_o = rsp_err_q;
`else
    assign bus_io.rsp_err_o = 1'b0;
`endif

    // Ready is masked by reset so no command can appear accepted while reset is held.
    assign bus_io.cmd_ready_o = (state_q == StIdle) && !wb_rst_i;
    assign bus_io.rsp_valid_o = (state_q == StResp);
    assign bus_io.rsp_dat_o   = rsp_dat_q;

    assign bus_io.wbm_cyc_o = cyc_q;
    assign bus_io.wbm_stb_o = cyc_q;
    assign bus_io.wbm_we_o  = we_q;
    assign bus_io.wbm_sel_o = sel_q;
    assign bus_io.wbm_adr_o = adr_q;
    assign bus_io.wbm_dat_o = dat_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: directed scenarios plus randomized transfers.
// Covers the WB_CMD_MASTER_TIMEOUT_EN build when that macro is defined for both files.
module tb_wb_cmd_master;
    localparam int unsigned TO = 4;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    localparam int MaxDelay = TO - 1;
`else
    localparam int MaxDelay = 6;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    wb_cmd_master_if bus ();

    wb_cmd_master #(.TIMEOUT_CYCLES(TO)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus_io   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish before 500us");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.cmd_valid_i = 1'b0;
        bus.cmd_we_i    = 1'b0;
        bus.cmd_adr_i   = '0;
        bus.cmd_dat_i   = '0;
        bus.cmd_sel_i   = '0;
        bus.rsp_ready_i = 1'b0;
        bus.wbm_ack_i   = 1'b0;
        bus.wbm_dat_i   = '0;
    endtask

    // One full transfer: the responder acks in stb cycle delay+1, the consumer stalls bp cycles.
    // Expected response: writes return 0, reads return the responder's data, never an error.
    task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int delay, input int bp,
                           input logic [31:0] rdata, input string tag);
        logic [31:0] exp_dat;
        logic [72:0] got73, exp73;
        logic [36:0] got37, exp37;
        logic [35:0] got36, exp36;
        logic [2:0]  got3;
        exp_dat = we ? 32'h0 : rdata;

        vectors++;
        if (bus.cmd_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL %s idle_ready: got %b want 1", tag, bus.cmd_ready_o);
        end
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = we;
        bus.cmd_adr_i   = adr;
        bus.cmd_dat_i   = dat;
        bus.cmd_sel_i   = sel;
        tick();
        bus.cmd_valid_i = 1'b0;
        bus.cmd_we_i    = 1'($urandom);
        bus.cmd_adr_i   = $urandom;
        bus.cmd_dat_i   = $urandom;
        bus.cmd_sel_i   = 4'($urandom);

        for (int k = 0; k <= delay; k++) begin
            got73 = {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o, bus.wbm_adr_o,
                     bus.wbm_dat_o, bus.cmd_ready_o, bus.rsp_valid_o};
            exp73 = {1'b1, 1'b1, we, sel, adr, dat, 1'b0, 1'b0};
            vectors++;
            if (got73 !== exp73) begin
                miscompares++;
                $display("FAIL %s bus_cycle%0d {cyc,stb,we,sel,adr,dat,rdy,rvld}: got %h want %h",
                         tag, k + 1, got73, exp73);
            end
            bus.wbm_ack_i = (k == delay);
            bus.wbm_dat_i = (k == delay) ? rdata : $urandom;
            tick();
        end
        bus.wbm_ack_i = 1'b0;
        bus.wbm_dat_i = $urandom;

        got37 = {bus.wbm_cyc_o, bus.wbm_stb_o, bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o,
                 bus.cmd_ready_o};
        exp37 = {1'b0, 1'b0, 1'b1, 1'b0, exp_dat, 1'b0};
        vectors++;
        if (got37 !== exp37) begin
            miscompares++;
            $display("FAIL %s response {cyc,stb,rvld,err,rdat,rdy}: got %h want %h",
                     tag, got37, exp37);
        end

        // A pending command and stray acks during the stall must both be ignored.
        for (int b = 0; b < bp; b++) begin
            bus.cmd_valid_i = 1'b1;
            bus.wbm_ack_i   = 1'($urandom);
            bus.wbm_dat_i   = $urandom;
            tick();
            got36 = {bus.wbm_stb_o, bus.cmd_ready_o, bus.rsp_valid_o, bus.rsp_err_o,
                     bus.rsp_dat_o};
            exp36 = {1'b0, 1'b0, 1'b1, 1'b0, exp_dat};
            vectors++;
            if (got36 !== exp36) begin
                miscompares++;
                $display("FAIL %s stall%0d {stb,rdy,rvld,err,rdat}: got %h want %h",
                         tag, b + 1, got36, exp36);
            end
        end
        bus.wbm_ack_i   = 1'b0;
        bus.rsp_ready_i = 1'b1;
        tick();
        bus.rsp_ready_i = 1'b0;
        bus.cmd_valid_i = 1'b0;
        got3 = {bus.wbm_stb_o, bus.rsp_valid_o, bus.cmd_ready_o};
        vectors++;
        if (got3 !== 3'b001) begin
            miscompares++;
            $display("FAIL %s consumed {stb,rvld,rdy}: got %b want 001", tag, got3);
        end
    endtask

    task automatic test_reset();
        logic [105:0] got;
        drive_idle();
        rst = 1'b1;
        tick();
        tick();
        got = {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o, bus.wbm_adr_o,
               bus.wbm_dat_o, bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o, bus.cmd_ready_o};
        vectors++;
        if (got !== 106'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0", got);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (bus.cmd_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: got %b want 1", bus.cmd_ready_o);
        end
        tick();
    endtask

    task automatic test_read();
        run_txn(1'b0, 32'h3000_0004, $urandom, 4'hF, 2, 0, 32'hDEAD_BEEF, "read");
    endtask

    task automatic test_write();
        logic [63:0] got;
        run_txn(1'b1, 32'h3000_0000, 32'h0000_00A5, 4'hF, 0, 0, $urandom, "write");
        tick();
        got = {bus.wbm_adr_o, bus.wbm_dat_o};
        vectors++;
        if (got !== {32'h3000_0000, 32'h0000_00A5}) begin
            miscompares++;
            $display("FAIL write_idle_hold {adr,dat}: got %h want 30000000000000a5", got);
        end
    endtask

    task automatic test_backpressure();
        run_txn(1'b0, 32'h4000_0010, $urandom, 4'h3, 1, 5, 32'h1234_5678, "bp_first");
        run_txn(1'b1, 32'h4000_0014, 32'hCAFE_F00D, 4'hC, 0, 0, $urandom, "bp_second");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 25; i++) begin
            run_txn(1'($urandom), $urandom, $urandom, 4'($urandom),
                    int'($urandom_range(MaxDelay, 0)), int'($urandom_range(3, 0)),
                    $urandom, "random");
        end
    endtask

    task automatic test_reset_mid_bus();
        logic [36:0] got37;
        logic [2:0]  got3;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = 1'b0;
        bus.cmd_adr_i   = 32'h5000_0000;
        bus.cmd_dat_i   = 32'h0;
        bus.cmd_sel_i   = 4'hF;
        tick();
        bus.cmd_valid_i = 1'b0;
        vectors++;
        if (bus.wbm_stb_o !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid_bus stb_before: got %b want 1", bus.wbm_stb_o);
        end
        #3;
        rst = 1'b1;
        #1;
        got37 = {bus.wbm_cyc_o, bus.wbm_stb_o, bus.rsp_valid_o, bus.cmd_ready_o, bus.wbm_adr_o,
                 1'b0};
        vectors++;
        if (got37 !== 37'h0) begin
            miscompares++;
            $display("FAIL rst_mid_bus async {cyc,stb,rvld,rdy,adr}: got %h want 0", got37);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.wbm_ack_i = 1'b1;
            bus.wbm_dat_i = $urandom;
            tick();
            got3 = {bus.wbm_stb_o, bus.rsp_valid_o, bus.cmd_ready_o};
            vectors++;
            if (got3 !== 3'b001) begin
                miscompares++;
                $display("FAIL rst_mid_bus after%0d {stb,rvld,rdy}: got %b want 001", i, got3);
            end
        end
        bus.wbm_ack_i = 1'b0;
        run_txn(1'b0, 32'h5000_0008, $urandom, 4'hF, 1, 1, 32'h0BAD_F00D, "after_reset");
    endtask

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        int          stb_cycles;
        logic [33:0] got;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = 1'b0;
        bus.cmd_adr_i   = 32'h6000_0000;
        bus.cmd_sel_i   = 4'hF;
        tick();
        bus.cmd_valid_i = 1'b0;
        stb_cycles = 0;
        for (int k = 0; k < 20 && bus.wbm_stb_o === 1'b1; k++) begin
            stb_cycles++;
            bus.wbm_ack_i = 1'b0;
            tick();
        end
        vectors++;
        if (stb_cycles != int'(TO)) begin
            miscompares++;
            $display("FAIL timeout_stb_cycles: got %0d want %0d", stb_cycles, TO);
        end
        got = {bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o};
        vectors++;
        if (got !== {1'b1, 1'b1, 32'h0}) begin
            miscompares++;
            $display("FAIL timeout_response {rvld,err,rdat}: got %h want 300000000", got);
        end
        bus.rsp_ready_i = 1'b1;
        tick();
        bus.rsp_ready_i = 1'b0;
        run_txn(1'b0, 32'h6000_0004, $urandom, 4'hF, int'(TO) - 1, 0, 32'h5555_AAAA,
                "ack_last_cycle");
    endtask
`else
    task automatic test_no_timeout();
        run_txn(1'b0, 32'h6000_0000, $urandom, 4'hF, 20, 0, 32'h5555_AAAA, "long_wait");
    endtask
`endif

    initial begin
        drive_idle();
        test_reset();
        test_read();
        test_write();
        test_backpressure();
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid_bus();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
